// File: rtl/instruction_memory_responder_if.sv
// instruction_memory_responder_if: fetch request, response and store-load signals
interface instruction_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instruction;
  logic [31:0] rsp_addr;
  logic        rsp_error;
  logic        load_enable;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  modport master (
    output req_valid, req_addr, rsp_ready, load_enable, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_instruction, rsp_addr, rsp_error
  );
  modport slave (
    input  req_valid, req_addr, rsp_ready, load_enable, load_addr, load_data,
    output req_ready, rsp_valid, rsp_instruction, rsp_addr, rsp_error
  );
endinterface

// File: rtl/instruction_memory_responder.sv
// instruction_memory_responder: fixed-latency instruction fetch responder with credit-limited output buffer
module instruction_memory_responder #(
  parameter int          DEPTH    = 64,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic clock,
  input  logic reset,
  instruction_memory_responder_if.slave bus,
  output logic busy
);
  localparam int IW = $clog2(DEPTH);
  localparam int FD = LATENCY + 1;
  localparam int AW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);
  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  logic [31:0] mem [DEPTH];
  beat_t       fifo [FD];
  beat_t       in_b, out_b;
  logic        in_v, out_v, req_err, ld_ok, push, pop;
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  logic [3:0]  pipe_cnt, outstanding;
  assign req_err = bus.req_addr[1:0] != 2'b0 || bus.req_addr[31:IW+2] != '0;
  assign ld_ok   = bus.load_addr[1:0] == 2'b0 && bus.load_addr[31:IW+2] == '0;
  assign in_v    = bus.req_valid && bus.req_ready;
  assign in_b    = '{err: req_err, addr: bus.req_addr,
                     data: req_err ? NOP_WORD : mem[bus.req_addr[IW+1:2]]};
  // store programming; illegal load addresses are silently dropped, contents survive reset
  always_ff @(posedge clock)
    if (bus.load_enable && ld_ok) mem[bus.load_addr[IW+1:2]] <= bus.load_data;
  generate
    if (LATENCY == 1) begin : g_direct
      assign out_v    = in_v;
      assign out_b    = in_b;
      assign pipe_cnt = '0;
    end else begin : g_pipe
      logic [LATENCY-2:0] sv;
      beat_t              sb [LATENCY-1];
      // valid bits of the latency stages, discarded by reset
      always_ff @(posedge clock or posedge reset)
        if (reset) sv <= '0;
        else begin
          sv[0] <= in_v;
          for (int i = 1; i < LATENCY - 1; i++) sv[i] <= sv[i-1];
        end
      // payload of the latency stages, qualified by the valid bits
      always_ff @(posedge clock) begin
        sb[0] <= in_b;
        for (int i = 1; i < LATENCY - 1; i++) sb[i] <= sb[i-1];
      end
      // number of beats still travelling through the stages
      always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < LATENCY - 1; i++) pipe_cnt = pipe_cnt + 4'(sv[i]);
      end
      assign out_v = sv[LATENCY-2];
      assign out_b = sb[LATENCY-2];
    end
  endgenerate
  assign push = out_v;
  assign pop  = bus.rsp_valid && bus.rsp_ready;
  // buffer payload write; credit limit guarantees a free slot on every push
  always_ff @(posedge clock)
    if (push) fifo[wr] <= out_b;
  // buffer pointers and occupancy
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr == AW'(FD - 1) ? '0 : wr + 1'b1;
      if (pop) rd <= rd == AW'(FD - 1) ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  assign outstanding         = pipe_cnt + 4'(cnt);
  assign busy                = outstanding != '0;
  assign bus.req_ready       = !reset && !bus.load_enable && outstanding < 4'(FD);
  assign bus.rsp_valid       = cnt != '0;
  assign bus.rsp_instruction = bus.rsp_valid ? fifo[rd].data : '0;
  assign bus.rsp_addr        = bus.rsp_valid ? fifo[rd].addr : '0;
  assign bus.rsp_error       = bus.rsp_valid && fifo[rd].err;
endmodule
